// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display path: FSM states,
// active-low 7-segment digit codes (bit order gfedcba) and the BCD adjust helper.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble correction: a nibble of 5..9 would overflow past 9 once doubled.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/score_display_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder (gfedcba).
// Non-decimal nibbles drive all segments off.
module bcd_to_seg7
    import score_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Sequential double-dabble converter driving three 7-segment digits from the score.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on HEX2/HEX1.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               clock,
    input  logic               scoreReset,
    input  logic [SCORE_W-1:0] score,
    output logic [11:0]        bcd,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic               busy,
    output logic               update
);

    localparam int SR_W  = 4 * BCD_DIGITS + SCORE_W;
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] last_score_q, last_score_d;
    logic [SR_W-1:0]    shift_q, shift_d;
    logic [SR_W-1:0]    shift_adj;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [11:0]        bcd_q, bcd_d;
    logic               update_q, update_d;
    logic [6:0]         seg [BCD_DIGITS];

    // Binary bits below the BCD field pass through; each BCD nibble gets its add-3 fix.
    assign shift_adj[SCORE_W-1:0] = shift_q[SCORE_W-1:0];

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign shift_adj[SCORE_W + 4*gi +: 4] = add3_if_ge5(shift_q[SCORE_W + 4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clock or posedge scoreReset) begin
        if (scoreReset) begin
            state_q      <= IDLE;
            last_score_q <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            bcd_q        <= '0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            bcd_q        <= bcd_d;
            update_q     <= update_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        bcd_d        = bcd_q;
        update_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (score != last_score_q) state_d = LOAD;
            end
            LOAD: begin
                last_score_d = score;
                shift_d      = {{(4*BCD_DIGITS){1'b0}}, score};
                bit_cnt_d    = '0;
                state_d      = SHIFT;
            end
            SHIFT: begin
                shift_d   = {shift_adj[SR_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(SCORE_W - 1)) state_d = DONE;
            end
            DONE: begin
                // update is registered so it rises on the same edge as bcd/HEX.
                bcd_d    = shift_q[SR_W-1:SCORE_W];
                update_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dec
            bcd_to_seg7 u_dec (
                .digit_i (bcd_q[4*gi +: 4]),
                .seg_o   (seg[gi])
            );
        end
    endgenerate

    assign bcd    = bcd_q;
    assign busy   = (state_q != IDLE);
    assign update = update_q;
    assign HEX0   = seg[0];

`ifdef LEADING_ZERO_BLANK_EN
    assign HEX2 = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg[2];
    assign HEX1 = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg[1];
`else
    assign HEX2 = seg[2];
    assign HEX1 = seg[1];
`endif

endmodule
